// File: rtl/muldiv_sequencer_if.sv
// Request/response and unit-handshake bundle between CtrlUnit, the Mult/Div units
// and muldiv_sequencer. The master modport is the CtrlUnit/unit side, the slave is the sequencer.
interface muldiv_sequencer_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_src;
    logic [31:0] operand_b;
    logic        abort;
    logic        req_ready;
    logic        busy;
    logic        start_mult;
    logic        mult_done;
    logic        start_div;
    logic        div_done;
    logic        div_src_sel;
    logic        high_write;
    logic        low_write;
    logic        done;
    logic        div_zero_exc;
    logic        timeout_exc;

    modport master (
        output req_valid, req_op, req_src, operand_b, abort, mult_done, div_done,
        input  req_ready, busy, start_mult, start_div, div_src_sel,
               high_write, low_write, done, div_zero_exc, timeout_exc
    );

    modport slave (
        input  req_valid, req_op, req_src, operand_b, abort, mult_done, div_done,
        output req_ready, busy, start_mult, start_div, div_src_sel,
               high_write, low_write, done, div_zero_exc, timeout_exc
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV through the iterative units with div-by-zero and timeout guards.
// Optional MULDIV_PERF_CNT_EN adds a 16-bit count of completed operations (op_count).
module muldiv_sequencer #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic                clock,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
`ifdef MULDIV_PERF_CNT_EN
    ,
    output logic [15:0]         op_count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             unit_div;
    logic             src_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             div_zero_q;
    logic             timeout_q;
    logic             unit_done;

    assign unit_done = unit_div ? bus.div_done : bus.mult_done;

    // Exceptions leave the FSM in IDLE, so they need their own one-cycle flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            unit_div   <= 1'b0;
            src_q      <= 1'b0;
            wait_cnt   <= '0;
            div_zero_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_op == 2'b00) begin
                            unit_div <= 1'b0;
                            src_q    <= 1'b0;
                            state    <= ST_LAUNCH;
                        end else if (bus.req_op == 2'b01) begin
                            if (bus.operand_b == '0) begin
                                div_zero_q <= 1'b1;
                            end else begin
                                unit_div <= 1'b1;
                                src_q    <= bus.req_src;
                                state    <= ST_LAUNCH;
                            end
                        end
                    end
                end
                ST_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (unit_done) begin
                        state <= ST_WRITE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state == ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.start_mult   = (state == ST_LAUNCH) && !unit_div;
    assign bus.start_div    = (state == ST_LAUNCH) && unit_div;
    assign bus.div_src_sel  = (state != ST_IDLE) && unit_div && src_q;
    assign bus.high_write   = (state == ST_WRITE);
    assign bus.low_write    = (state == ST_WRITE);
    assign bus.done         = (state == ST_WRITE);
    assign bus.div_zero_exc = div_zero_q;
    assign bus.timeout_exc  = timeout_q;

`ifdef MULDIV_PERF_CNT_EN
    // Only successful completions reach WRITE, so that is the only thing counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_count <= 16'h0000;
        end else if (state == ST_WRITE) begin
            op_count <= op_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected completion/exception
// responses, a negedge monitor pops and compares them whenever the DUT reports one.
module tb_muldiv_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    muldiv_sequencer_if bus ();

`ifdef MULDIV_PERF_CNT_EN
    logic [15:0] op_count;
`endif

    muldiv_sequencer #(.TIMEOUT(48), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef MULDIV_PERF_CNT_EN
        ,
        .op_count (op_count)
`endif
    );

    localparam logic [9:0] IDLE_VEC  = 10'b10_0000_0000;
    localparam logic [5:0] RESP_DONE = 6'b111000;
    localparam logic [5:0] RESP_DZ   = 6'b000100;
    localparam logic [5:0] RESP_TO   = 6'b000010;

    int test_cnt = 0;
    int fail_cnt = 0;
    int start_mult_cnt = 0;
    int start_div_cnt = 0;
    int write_cnt = 0;
    int src_bad_cnt = 0;
    logic exp_src = 1'b0;
    logic [5:0] exp_q[$];

    function automatic logic [9:0] out_vec();
        return {bus.req_ready, bus.busy, bus.start_mult, bus.start_div, bus.div_src_sel,
                bus.high_write, bus.low_write, bus.done, bus.div_zero_exc, bus.timeout_exc};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called one delta after a rising edge; the request is sampled at the next edge.
    task automatic apply_stimulus(input logic [1:0] op, input logic src, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src   = src;
        bus.operand_b = b;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_src   = 1'b0;
        bus.operand_b = 32'h0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_output(name, 32'(ok), 32'd1);
        @(posedge clock);
        #1;
    endtask

    // Monitor: tallies pulses and pops the scoreboard on every reported response.
    initial begin
        logic [5:0] resp;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (bus.start_mult) start_mult_cnt++;
                if (bus.start_div)  start_div_cnt++;
                if (bus.high_write) write_cnt++;
                if (bus.busy && (bus.div_src_sel !== exp_src)) src_bad_cnt++;
                if (bus.done || bus.div_zero_exc || bus.timeout_exc) begin
                    resp = {bus.done, bus.high_write, bus.low_write,
                            bus.div_zero_exc, bus.timeout_exc, bus.div_src_sel};
                    if (exp_q.size() == 0)
                        check_output("unexpected_response", 32'(resp), 32'd0);
                    else
                        check_output("response", 32'(resp), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sm0, sd0, wr0, sb0, waits;
        bit seen;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_src   = 1'b0;
        bus.operand_b = 32'h0;
        bus.abort     = 1'b0;
        bus.mult_done = 1'b0;
        bus.div_done  = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset_outputs", 32'(out_vec()), 32'(IDLE_VEC));
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check_output("idle_outputs", 32'(out_vec()), 32'(IDLE_VEC));
        @(posedge clock);
        #1;

        apply_stimulus(2'b10, 1'b1, 32'h0);
        repeat (2) begin
            @(negedge clock);
            check_output("reserved_op10", 32'(out_vec()), 32'(IDLE_VEC));
        end
        @(posedge clock);
        #1;
        apply_stimulus(2'b11, 1'b0, 32'd5);
        @(negedge clock);
        check_output("reserved_op11", 32'(out_vec()), 32'(IDLE_VEC));
        @(posedge clock);
        #1;

        sm0 = start_mult_cnt; sd0 = start_div_cnt; wr0 = write_cnt;
        exp_q.push_back(RESP_DONE);
        apply_stimulus(2'b00, 1'b0, 32'h0);
        @(negedge clock);
        check_output("mult_launch", 32'({bus.busy, bus.start_mult, bus.start_div, bus.req_ready}), 32'b1100);
        repeat (5) @(posedge clock);
        #1 bus.mult_done = 1'b1;
        @(posedge clock);
        #1 bus.mult_done = 1'b0;
        wait_idle("mult_complete");
        check_output("mult_start_pulses", 32'(start_mult_cnt - sm0), 32'd1);
        check_output("mult_no_div_start", 32'(start_div_cnt - sd0), 32'd0);
        check_output("mult_write_cycles", 32'(write_cnt - wr0), 32'd1);

        sm0 = start_mult_cnt; sd0 = start_div_cnt; wr0 = write_cnt; sb0 = src_bad_cnt;
        exp_src = 1'b1;
        exp_q.push_back(RESP_DONE | 6'b000001);
        apply_stimulus(2'b01, 1'b1, 32'd7);
        @(negedge clock);
        check_output("div_launch", 32'({bus.busy, bus.start_mult, bus.start_div, bus.div_src_sel}), 32'b1011);
        @(posedge clock);
        #1 bus.mult_done = 1'b1;
        @(posedge clock);
        #1 bus.mult_done = 1'b0;
        @(posedge clock);
        #1 bus.div_done = 1'b1;
        @(posedge clock);
        #1 bus.div_done = 1'b0;
        wait_idle("div_complete");
        exp_src = 1'b0;
        check_output("div_start_pulses", 32'(start_div_cnt - sd0), 32'd1);
        check_output("div_no_mult_start", 32'(start_mult_cnt - sm0), 32'd0);
        check_output("div_write_cycles", 32'(write_cnt - wr0), 32'd1);
        check_output("div_src_stable", 32'(src_bad_cnt - sb0), 32'd0);

        sd0 = start_div_cnt; wr0 = write_cnt;
        exp_q.push_back(RESP_DZ);
        apply_stimulus(2'b01, 1'b1, 32'h0);
        @(negedge clock);
        check_output("divzero_ready", 32'({bus.req_ready, bus.busy}), 32'b10);
        repeat (3) @(posedge clock);
        #1;
        check_output("divzero_no_start", 32'(start_div_cnt - sd0), 32'd0);
        check_output("divzero_no_write", 32'(write_cnt - wr0), 32'd0);

        wr0 = write_cnt;
        waits = 0;
        seen = 1'b0;
        exp_q.push_back(RESP_TO);
        apply_stimulus(2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.timeout_exc) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy && !bus.start_mult) waits++;
        end
        check_output("timeout_seen", 32'(seen), 32'd1);
        check_output("timeout_wait_cycles", 32'(waits), 32'd48);
        check_output("timeout_no_write", 32'(write_cnt - wr0), 32'd0);
        @(posedge clock);
        #1;

        wr0 = write_cnt;
        exp_q.push_back(RESP_DONE);
        apply_stimulus(2'b00, 1'b0, 32'h0);
        repeat (48) @(posedge clock);
        #1 bus.mult_done = 1'b1;
        @(posedge clock);
        #1 bus.mult_done = 1'b0;
        wait_idle("late_done_complete");
        check_output("late_done_write", 32'(write_cnt - wr0), 32'd1);

        wr0 = write_cnt;
        apply_stimulus(2'b01, 1'b0, 32'd5);
        @(posedge clock);
        #1;
        bus.abort    = 1'b1;
        bus.div_done = 1'b1;
        @(posedge clock);
        #1;
        bus.abort    = 1'b0;
        bus.div_done = 1'b0;
        @(negedge clock);
        check_output("abort_idle", 32'(out_vec()), 32'(IDLE_VEC));
        repeat (2) @(posedge clock);
        #1;
        check_output("abort_no_write", 32'(write_cnt - wr0), 32'd0);

        wr0 = write_cnt;
        apply_stimulus(2'b00, 1'b0, 32'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1 check_output("reset_midwait", 32'(out_vec()), 32'(IDLE_VEC));
        @(posedge clock);
        #1 reset = 1'b1;
        bus.mult_done = 1'b1;
        @(posedge clock);
        #1 bus.mult_done = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("reset_midwait_idle", 32'(out_vec()), 32'(IDLE_VEC));
        check_output("reset_midwait_no_write", 32'(write_cnt - wr0), 32'd0);
`ifdef MULDIV_PERF_CNT_EN
        check_output("op_count_reset", 32'(op_count), 32'd0);
`endif
        @(posedge clock);
        #1;

        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(RESP_DONE);
            apply_stimulus(2'b00, 1'b0, 32'h0);
            bus.mult_done = 1'b1;
            @(posedge clock);
            #1;
            @(posedge clock);
            #1 bus.mult_done = 1'b0;
            @(negedge clock);
            check_output("min_latency_done", 32'(bus.done), 32'd1);
            @(posedge clock);
            #1;
        end
`ifdef MULDIV_PERF_CNT_EN
        check_output("op_count_three", 32'(op_count), 32'd3);
`endif

        repeat (2) @(posedge clock);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controller that sits between CtrlUnit and the iterative Mult/Div units.
- Accepts one MULT/DIV request and launches the selected unit with a one-cycle start pulse.
- Waits for that unit's done handshake, then asserts the HI/LO register write enables for exactly one cycle.
- Detects divide-by-zero before launch and bounds every operation with a timeout, so CtrlUnit only waits on `busy` and reacts to `done`/exception pulses.

Parameters:
- TIMEOUT, 48, maximum WAIT cycles before the operation is abandoned (must be >= 2).
- CNT_W, 6, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe from CtrlUnit.
- req_op  in  2  00=MULT, 01=DIV, 10/11 reserved.
- req_src  in  1  divider operand source select, latched at accept.
- operand_b  in  32  divisor value, sampled at accept for the zero check.
- abort  in  1  cancels the in-flight operation.
- req_ready  out  1  high only in IDLE.
- busy  out  1  high in LAUNCH, WAIT and WRITE.
- start_mult  out  1  one-cycle launch pulse to Mult.
- mult_done  in  1  Mult completion (level or pulse).
- start_div  out  1  one-cycle launch pulse to Div.
- div_done  in  1  Div completion (level or pulse).
- div_src_sel  out  1  held latched req_src while busy on a DIV; 0 otherwise.
- high_write  out  1  HI load enable.
- low_write  out  1  LO load enable.
- done  out  1  one-cycle completion pulse.
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse.
- timeout_exc  out  1  one-cycle timeout exception pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, latched unit/src cleared.
  - All outputs 0 except req_ready=1.
  - Reset mid-operation abandons it with no HI/LO write.
- States: IDLE, LAUNCH, WAIT, WRITE. All pulse outputs are registered from the state, so each lasts exactly one cycle.
- IDLE, sampled with req_valid=1:
  - req_op=01 and operand_b==0 → div_zero_exc=1 next cycle; state stays IDLE; no start, no write.
  - req_op=00 → latch unit=MULT; go to LAUNCH.
  - req_op=01 with nonzero divisor → latch unit=DIV and src; go to LAUNCH.
  - req_op=10/11 → ignored; no outputs change.
- LAUNCH:
  - start_mult or start_div=1 according to the latched unit; counter=0.
  - Next state WAIT unconditionally; abort is honoured only from WAIT.
- WAIT (counter increments each cycle):
  - abort=1 → IDLE, no write, no pulse. Abort has priority over done.
  - Selected unit's done=1 → WRITE. The unselected unit's done is ignored.
  - counter==TIMEOUT-1 with no done → timeout_exc=1, go to IDLE. If done and timeout occur in the same cycle, done wins.
- WRITE:
  - high_write=low_write=done=1 for one cycle, then IDLE.
  - req_ready returns the following cycle; no back-to-back accept during WRITE.
- Minimum latency: accept at edge N; start at N+1; if done is seen in the first WAIT cycle, the write/done pulse occurs at N+3.
- req_valid while busy: ignored; not queued.
- div_src_sel must be stable from LAUNCH through WRITE for DIV operations.

Optional Feature:
- Macro: MULDIV_PERF_CNT_EN.
- Defined:
  - Adds output `op_count` [15:0], reset to 0.
  - Increments by 1 on every WRITE cycle; wraps 0xFFFF→0x0000.
  - Aborted, timed-out and div-zero operations are not counted.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, release → req_ready=1, all other outputs 0. Then req_op=10 with req_valid=1 → no change.
- MULT: req_op=00, mult_done asserted 5 cycles after start_mult → one start_mult pulse; high_write=low_write=done=1 for exactly 1 cycle; div_src_sel=0.
- DIV with req_src=1 and operand_b=7: div_done after 3 cycles; mult_done pulsed during WAIT → mult_done ignored; div_src_sel=1 from LAUNCH through WRITE; single write pulse.
- DIV with operand_b=0 → div_zero_exc for 1 cycle; no start_div, no write; req_ready stays 1.
- Timeout and abort:
  - TIMEOUT=48, no done ever → timeout_exc exactly 48 WAIT cycles after start, no write.
  - Separate run: abort and div_done asserted in the same cycle → IDLE, no write.
- Reset mid-WAIT, then MULT_PERF:
  - Assert reset during WAIT → immediate IDLE, no write.
  - With MULDIV_PERF_CNT_EN, complete 3 MULTs → op_count=3.
